ser_tx_frame: RTL
=================

// Module: ser_tx_frame
// PURPOSE
//  Parallel-to-serial frame transmitter: accepts a WIDTH-bit word on a
//  load/ready handshake and drives it out on one line as a start bit (0),
//  WIDTH data bits LSB first, then a stop bit (1). It is the sending end
//  for parallel register data, e.g. the 4-bit word held by a D-type data
//  register, toward a serial receiver on a single wire.
// PARAMETERS
//  WIDTH         4  data bits per frame (>=1)
//  CLKS_PER_BIT  4  clock cycles each serial bit is held on ser_out (>=1)
// PORTS
//  clock    in   1      single system clock, rising edge
//  reset    in   1      asynchronous, active-high reset
//  data_in  in   WIDTH  word to transmit, sampled only on acceptance
//  load     in   1      request to send data_in
//  ready    out  1      1 = transmitter idle, load is accepted
//  busy     out  1      1 = frame in progress (start..stop)
//  ser_out  out  1      serial line, idles high
//  done     out  1      one-cycle pulse when a frame has completed
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-frame): state IDLE, ser_out=1,
//    ready=1, busy=0, done=0, shift reg=0, bit/cycle counters=0. The frame
//    in progress is abandoned; no done pulse.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - FSM states: IDLE, START, DATA, STOP.
//    IDLE : ser_out=1, ready=1. On edge with load=1 -> capture data_in into
//           shift reg, go START. load=0 -> stay. done deasserts after 1 cycle.
//    START: ser_out=0 for CLKS_PER_BIT cycles -> DATA, bit index 0.
//    DATA : ser_out=shift reg bit [index], held CLKS_PER_BIT cycles; index
//           increments each bit period; after bit WIDTH-1 -> STOP.
//    STOP : ser_out=1 for CLKS_PER_BIT cycles -> IDLE with done=1.
//  - Timing, acceptance at edge E0 (period C=CLKS_PER_BIT):
//    after E0: ser_out=0, ready=0, busy=1; after E0+k*C (k=1..WIDTH):
//    ser_out=data[k-1]; after E0+(WIDTH+1)*C: ser_out=1 (stop);
//    after E0+(WIDTH+2)*C: ready=1, busy=0, done=1 for exactly one cycle.
//  - busy = ~ready at all times; done never coincides with busy=1.
//  - load while ready=0 is ignored (not queued); data_in changes after
//    capture do not affect the frame in progress.
//  - Back-to-back: load=1 in the done cycle is accepted (ready=1); next
//    start bit follows immediately, no extra idle cycle.
//  - Cycle counter width $clog2(CLKS_PER_BIT) (min 1 bit), wraps at C-1;
//    bit index width $clog2(WIDTH) (min 1 bit), never exceeds WIDTH-1.
//  - CLKS_PER_BIT=1: one bit per cycle, frame = WIDTH+2 cycles.
// TESTING
//  1 Reset: assert reset mid-cycle without clock edge -> ser_out=1,
//    ready=1, busy=0, done=0 immediately.
//  2 WIDTH=4,C=4, load 4'b1010 -> ser_out 0,0,1,0,1,1 each held 4 cycles;
//    done=1 exactly 24 cycles after acceptance edge, for one cycle.
//  3 load held high, data_in changed to 4'b0110 during frame of 4'b1001
//    -> frame carries 1001 only; 0110 sent as next frame right after done.
//  4 Reset asserted in DATA bit 2 of 4'b1111 -> ser_out=1 at once, no done;
//    after release, load 4'b0001 -> clean frame 0,1,0,0,0,1.
//  5 C=1, WIDTH=4, load 4'b0011 -> ser_out 0,1,1,0,0,1 on consecutive
//    cycles, done 6 cycles after acceptance.
//  6 Random words, random load gaps, 200 frames -> bench deserializer
//    matches every word; ready/busy always complementary.

Source files
------------

// File: rtl/ser_tx_frame.sv
// Parallel-to-serial frame transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1),
// each bit held CLKS_PER_BIT clocks, with a load/ready handshake and a one-cycle done pulse.
module ser_tx_frame #(
   parameter int WIDTH        = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             busy,
   output logic             ser_out,
   output logic             done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [IW-1:0]    bitIdx_q, bitIdx_d;
   logic [CW-1:0]    cycCnt_q, cycCnt_d;
   logic             serOut_q, serOut_d;
   logic             ready_q, ready_d;
   logic             busy_q;
   logic             done_q, done_d;
   logic             lastCycle;
   logic [IW-1:0]    nextIdx;

   assign lastCycle = (cycCnt_q == CYC_LAST);
   assign nextIdx   = bitIdx_q + IW'(1);

   // Every output is computed one cycle ahead so the line and flags come straight from flops.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitIdx_d = bitIdx_q;
      cycCnt_d = cycCnt_q;
      serOut_d = serOut_q;
      ready_d  = ready_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cycCnt_d = '0;
            bitIdx_d = '0;
            serOut_d = 1'b1;
            ready_d  = 1'b1;
            if (load) begin
               shift_d  = data_in;
               state_d  = START;
               serOut_d = 1'b0;
               ready_d  = 1'b0;
            end
         end
         START: begin
            if (lastCycle) begin
               cycCnt_d = '0;
               bitIdx_d = '0;
               state_d  = DATA;
               serOut_d = shift_q[0];
            end else begin
               cycCnt_d = cycCnt_q + CW'(1);
            end
         end
         DATA: begin
            if (lastCycle) begin
               cycCnt_d = '0;
               if (bitIdx_q == IDX_LAST) begin
                  state_d  = STOP;
                  serOut_d = 1'b1;
               end else begin
                  bitIdx_d = nextIdx;
                  serOut_d = shift_q[nextIdx];
               end
            end else begin
               cycCnt_d = cycCnt_q + CW'(1);
            end
         end
         STOP: begin
            if (lastCycle) begin
               cycCnt_d = '0;
               state_d  = IDLE;
               ready_d  = 1'b1;
               done_d   = 1'b1;
            end else begin
               cycCnt_d = cycCnt_q + CW'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            serOut_d = 1'b1;
            ready_d  = 1'b1;
         end
      endcase
   end

   // Reset abandons any frame in flight and parks the line high without a done pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         bitIdx_q <= '0;
         cycCnt_q <= '0;
         serOut_q <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitIdx_q <= bitIdx_d;
         cycCnt_q <= cycCnt_d;
         serOut_q <= serOut_d;
         ready_q  <= ready_d;
         busy_q   <= ~ready_d;
         done_q   <= done_d;
      end
   end

   assign ready   = ready_q;
   assign busy    = busy_q;
   assign ser_out = serOut_q;
   assign done    = done_q;

endmodule
